key_schedule_multi: RTL and testbench

KEY_SCHEDULE_MULTI -- requirements
Module: key_schedule_multi

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes_sbox.sv | 17 +
 rtl/key_schedule_multi.sv | 166 ++++++++++++++++
 tb/tb_key_schedule_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule constants: key_len encodings, Nk/Nr/W tables, Rcon, GF(2^8) helpers.
// The storage depth depends on KEY_SCHEDULE_AES256_EN.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_DEF = 2'b11;

`ifdef KEY_SCHEDULE_AES256_EN
    localparam int W_MAX  = 60;
    localparam int NK_MAX = 8;
`else
    localparam int W_MAX  = 52;
    localparam int NK_MAX = 6;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_EXPAND} state_e;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KL_192:  return 4'd6;
            KL_256:  return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        return nk_of(kl) + 4'd6;
    endfunction

    function automatic logic [5:0] w_of(input logic [1:0] kl);
        return {nr_of(kl), 2'b00} + 6'd4;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse, and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq, acc;
        sq  = gf_mul(a, a);
        acc = sq;
        for (int k = 0; k < 6; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 forward S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    logic [7:0] b;

    always_comb begin
        b        = gf_inv(in_byte);
        out_byte = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                     ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_schedule_multi.sv
// AES-128/192/256 key expansion, one word per clock, with random-access round-key read.
// AES-256 support (60-word storage, Nk==8 SubWord step) is built only with KEY_SCHEDULE_AES256_EN.
module key_schedule_multi
    import aes_pkg::*;
#(
    parameter logic [1:0] KEY_LEN_DEF = 2'b00
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         busy,
    output logic         finish,
    output logic         keys_valid,
    output logic         err
);

    state_e      state_q, state_d;
    logic [1:0]  kl_q, kl_d;
    logic [5:0]  idx_q, idx_d;
    logic [2:0]  pos_q, pos_d;
    logic [3:0]  rc_q, rc_d;
    logic        keys_valid_q, keys_valid_d;
    logic        finish_q, finish_d;
    logic        err_q, err_d;
    logic [31:0] w_q [W_MAX];
    logic [31:0] w_d [W_MAX];

    logic [1:0]  kl_eff;
    logic        kl_ok;
    logic [3:0]  nk;
    logic [2:0]  nk_m1;
    logic        last;
    logic [31:0] prev, old, sub_in, sub_out, t, new_word;
    logic [5:0]  rk_base;

    always_comb begin
        kl_eff = (key_len == KL_DEF) ? KEY_LEN_DEF : key_len;
`ifdef KEY_SCHEDULE_AES256_EN
        kl_ok  = (kl_eff == KL_128) || (kl_eff == KL_192) || (kl_eff == KL_256);
`else
        kl_ok  = (kl_eff == KL_128) || (kl_eff == KL_192);
`endif
    end

`ifndef KEY_SCHEDULE_AES256_EN
    logic unused_key_lo;
    assign unused_key_lo = ^key[63:0];
`endif

    // pos_q tracks i mod Nk so no divider is needed; rc_q is the next Rcon index.
    always_comb begin
        nk       = nk_of(kl_q);
        nk_m1    = 3'(nk - 4'd1);
        last     = (idx_q == w_of(kl_q) - 6'd1);
        prev     = w_q[idx_q - 6'd1];
        old      = w_q[idx_q - 6'(nk)];
        sub_in   = (pos_q == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        t        = prev;
        if (pos_q == 3'd0) t = sub_out ^ {rcon(rc_q), 24'h0};
`ifdef KEY_SCHEDULE_AES256_EN
        else if (nk == 4'd8 && pos_q == 3'd4) t = sub_out;
`endif
        new_word = old ^ t;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in[8*g +: 8]),
            .out_byte (sub_out[8*g +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start && kl_ok) state_d = ST_LOAD;
            ST_LOAD:   state_d = last ? ST_IDLE : ST_EXPAND;
            ST_EXPAND: if (last) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        kl_d         = kl_q;
        idx_d        = idx_q;
        pos_d        = pos_q;
        rc_d         = rc_q;
        keys_valid_d = keys_valid_q;
        finish_d     = 1'b0;
        err_d        = 1'b0;
        w_d          = w_q;
        case (state_q)
            ST_IDLE: begin
                if (start && kl_ok) begin
                    kl_d         = kl_eff;
                    idx_d        = 6'(nk_of(kl_eff));
                    pos_d        = 3'd0;
                    rc_d         = 4'd1;
                    keys_valid_d = 1'b0;
                    for (int k = 0; k < NK_MAX; k++)
                        if (k < int'(nk_of(kl_eff))) w_d[k] = key[255-32*k -: 32];
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_LOAD, ST_EXPAND: begin
                w_d[idx_q] = new_word;
                idx_d      = idx_q + 6'd1;
                pos_d      = (pos_q == nk_m1) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0) rc_d = rc_q + 4'd1;
                if (last) begin
                    finish_d     = 1'b1;
                    keys_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kl_q         <= KL_128;
            idx_q        <= '0;
            pos_q        <= '0;
            rc_q         <= '0;
            keys_valid_q <= 1'b0;
            finish_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            kl_q         <= kl_d;
            idx_q        <= idx_d;
            pos_q        <= pos_d;
            rc_q         <= rc_d;
            keys_valid_q <= keys_valid_d;
            finish_q     <= finish_d;
            err_q        <= err_d;
        end
    end

    // Word storage is deliberately not reset; keys_valid gates every read.
    always_ff @(posedge clk) begin
        w_q <= w_d;
    end

    always_comb begin
        rk_base = {rk_idx, 2'b00};
        rk_out  = '0;
        if (keys_valid_q && rk_idx <= nr_of(kl_q))
            rk_out = {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]};
    end

    assign busy       = (state_q != ST_IDLE);
    assign finish     = finish_q;
    assign keys_valid = keys_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_key_schedule_multi.sv
// Directed bench for key_schedule_multi using FIPS-197 appendix A vectors.
// Runs the AES-256 case when KEY_SCHEDULE_AES256_EN is defined, else the unsupported-length case.
module tb_key_schedule_multi;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'b00;
    logic [255:0] key = '0;
    logic [3:0]   rk_idx = 4'd0;
    logic [127:0] rk_out;
    logic         busy, finish, keys_valid, err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    key_schedule_multi dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_len    (key_len),
        .key        (key),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .busy       (busy),
        .finish     (finish),
        .keys_valid (keys_valid),
        .err        (err)
    );

    task automatic drive_start(input logic [1:0] kl, input logic [255:0] k);
        @(negedge clk);
        start = 1'b1; key_len = kl; key = k;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_finish(output int edges);
        edges = -1;
        for (int e = 1; e <= 100; e++) begin
            @(posedge clk); #1;
            if (finish) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic read_rk(input logic [3:0] i, output logic [127:0] v);
        @(negedge clk);
        rk_idx = i;
        #1 v = rk_out;
    endtask

    task automatic test_reset;
        logic [127:0] v;
        rst = 1'b1; start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        n_checks += 4;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (finish !== 1'b0)     begin n_fail++; $display("FAIL reset_finish got %b want 0", finish); end
        if (err !== 1'b0)        begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL reset_keys_valid got %b want 0", keys_valid); end
        read_rk(4'd0, v);
        n_checks++;
        if (v !== 128'h0) begin n_fail++; $display("FAIL reset_rk_out got %h want 0", v); end
        rst = 1'b0;
    endtask

    task automatic test_aes128;
        int e;
        logic [127:0] v;
        drive_start(2'b00, K128);
        n_checks += 2;
        if (busy !== 1'b1)       begin n_fail++; $display("FAIL a128_busy got %b want 1", busy); end
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL a128_kv_clear got %b want 0", keys_valid); end
        wait_finish(e);
        n_checks += 3;
        if (e !== 40)            begin n_fail++; $display("FAIL a128_finish_edge got %0d want 40", e); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL a128_busy_end got %b want 0", busy); end
        if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL a128_kv got %b want 1", keys_valid); end
        @(posedge clk); #1;
        n_checks++;
        if (finish !== 1'b0) begin n_fail++; $display("FAIL a128_finish_pulse got %b want 0", finish); end
        read_rk(4'd0, v);
        n_checks++;
        if (v !== K128[255:128]) begin n_fail++; $display("FAIL a128_rk0 got %h want %h", v, K128[255:128]); end
        read_rk(4'd1, v);
        n_checks++;
        if (v !== 128'ha0fafe1788542cb123a339392a6c7605) begin n_fail++; $display("FAIL a128_rk1 got %h", v); end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL a128_rk10 got %h", v); end
        read_rk(4'd11, v);
        n_checks++;
        if (v !== 128'h0) begin n_fail++; $display("FAIL a128_rk11 got %h want 0", v); end
    endtask

    task automatic test_back_to_back;
        int e;
        logic [127:0] v;
        drive_start(2'b00, K128);
        wait_finish(e);
        n_checks++;
        if (e !== 40) begin n_fail++; $display("FAIL b2b_first_edge got %0d want 40", e); end
        drive_start(2'b01, K192);
        n_checks += 2;
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_kv_clear got %b want 0", keys_valid); end
        if (busy !== 1'b1)       begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
        wait_finish(e);
        n_checks++;
        if (e !== 46) begin n_fail++; $display("FAIL a192_finish_edge got %0d want 46", e); end
        read_rk(4'd1, v);
        n_checks++;
        if (v !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5) begin n_fail++; $display("FAIL a192_rk1 got %h", v); end
        read_rk(4'd12, v);
        n_checks++;
        if (v[31:0] !== 32'h01002202) begin n_fail++; $display("FAIL a192_w51 got %h want 01002202", v[31:0]); end
        read_rk(4'd13, v);
        n_checks++;
        if (v !== 128'h0) begin n_fail++; $display("FAIL a192_rk13 got %h want 0", v); end
    endtask

`ifdef KEY_SCHEDULE_AES256_EN
    task automatic test_aes256;
        int e;
        logic [127:0] v;
        drive_start(2'b10, K256);
        wait_finish(e);
        n_checks++;
        if (e !== 52) begin n_fail++; $display("FAIL a256_finish_edge got %0d want 52", e); end
        read_rk(4'd1, v);
        n_checks++;
        if (v !== K256[127:0]) begin n_fail++; $display("FAIL a256_rk1 got %h", v); end
        read_rk(4'd14, v);
        n_checks++;
        if (v[31:0] !== 32'h706c631e) begin n_fail++; $display("FAIL a256_w59 got %h want 706c631e", v[31:0]); end
        read_rk(4'd15, v);
        n_checks++;
        if (v !== 128'h0) begin n_fail++; $display("FAIL a256_rk15 got %h want 0", v); end
    endtask
`else
    task automatic test_unsupported;
        logic [127:0] v;
        drive_start(2'b10, K256);
        n_checks += 3;
        if (err !== 1'b1)        begin n_fail++; $display("FAIL unsup_err got %b want 1", err); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL unsup_busy got %b want 0", busy); end
        if (keys_valid !== 1'b1) begin n_fail++; $display("FAIL unsup_kv got %b want 1", keys_valid); end
        @(posedge clk); #1;
        n_checks += 2;
        if (err !== 1'b0)  begin n_fail++; $display("FAIL unsup_err_pulse got %b want 0", err); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL unsup_busy_later got %b want 0", busy); end
        read_rk(4'd12, v);
        n_checks++;
        if (v[31:0] !== 32'h01002202) begin n_fail++; $display("FAIL unsup_sched_kept got %h want 01002202", v[31:0]); end
    endtask
`endif

    task automatic test_start_while_busy;
        int e;
        logic err_seen;
        logic [127:0] v;
        drive_start(2'b00, K128);
        e = 0;
        err_seen = 1'b0;
        while (e < 100) begin
            @(negedge clk);
            start = (e == 9);
            key_len = 2'b01; key = K192;
            @(posedge clk); #1;
            e++;
            if (err) err_seen = 1'b1;
            if (finish) break;
        end
        start = 1'b0;
        n_checks += 2;
        if (e !== 40)         begin n_fail++; $display("FAIL busy_start_edge got %0d want 40", e); end
        if (err_seen !== 1'b0) begin n_fail++; $display("FAIL busy_start_err got %b want 0", err_seen); end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL busy_start_rk10 got %h", v); end
    endtask

    task automatic test_reset_mid;
        int e;
        logic fin_seen;
        logic [127:0] v;
        drive_start(2'b00, K128);
        fin_seen = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk); #1;
            if (finish) fin_seen = 1'b1;
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        if (finish) fin_seen = 1'b1;
        n_checks += 3;
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (keys_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_kv got %b want 0", keys_valid); end
        if (fin_seen !== 1'b0)   begin n_fail++; $display("FAIL rmid_finish got %b want 0", fin_seen); end
        @(negedge clk);
        rst = 1'b0; start = 1'b1; key_len = 2'b00; key = K128;
        @(posedge clk); #1;
        start = 1'b0;
        wait_finish(e);
        n_checks++;
        if (e !== 40) begin n_fail++; $display("FAIL rmid_second_edge got %0d want 40", e); end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL rmid_rk10 got %h", v); end
    endtask

    task automatic test_keylen_default;
        int e;
        logic [127:0] v;
        drive_start(2'b11, K128);
        wait_finish(e);
        n_checks++;
        if (e !== 40) begin n_fail++; $display("FAIL kldef_edge got %0d want 40", e); end
        read_rk(4'd10, v);
        n_checks++;
        if (v !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin n_fail++; $display("FAIL kldef_rk10 got %h", v); end
    endtask

    initial begin
        test_reset;
        test_aes128;
        test_back_to_back;
`ifdef KEY_SCHEDULE_AES256_EN
        test_aes256;
`else
        test_unsupported;
`endif
        test_start_while_busy;
        test_reset_mid;
        test_keylen_default;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
